// File: rtl/lsu_axi_master_pkg.sv
// Shared types and AXI constants for the LSU AXI4 initiator and its watchdog.
package lsu_axi_master_pkg;

  localparam int ID_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW_W = 3'd3,
    ST_B    = 3'd4,
    ST_RESP = 3'd5
  } lsu_state_e;

  localparam logic [1:0]      BURST_INCR      = 2'b01;
  localparam logic [1:0]      RESP_OKAY       = 2'b00;
  localparam logic [2:0]      SIZE_B          = 3'd0;
  localparam logic [2:0]      SIZE_H          = 3'd1;
  localparam logic [2:0]      SIZE_W          = 3'd2;
  localparam logic [ID_W-1:0] DEFAULT_ID      = '0;
  localparam logic [7:0]      SINGLE_BEAT_LEN = 8'd0;

  // States in which a bus transaction is outstanding.
  function automatic logic is_busy(lsu_state_e s);
    return (s == ST_AR) || (s == ST_R) || (s == ST_AW_W) || (s == ST_B);
  endfunction

endpackage

// File: rtl/lsu_axi_master_if.sv
// AXI4 single-beat read/write channel bundle between the LSU initiator and the crossbar.
interface lsu_axi_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import lsu_axi_master_pkg::*;

  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     arid;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;

  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic                rlast;
  logic [ID_W-1:0]     rid;

  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;

  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid, arid, arlen, arsize, arburst,
    input  arready,
    input  rdata, rresp, rvalid, rlast, rid,
    output rready,
    output awaddr, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  araddr, arvalid, arid, arlen, arsize, arburst,
    output arready,
    output rdata, rresp, rvalid, rlast, rid,
    input  rready,
    input  awaddr, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/lsu_axi_watchdog.sv
// Transaction watchdog: counts busy cycles since request accept and flags expiry.
module lsu_axi_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] count_reg;

  assign expired = (count_reg >= LIMIT);

  // Saturates at the limit so a stuck FSM cannot wrap the counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (run && !expired) begin
      count_reg <= count_reg + 16'd1;
    end
  end

endmodule

// File: rtl/lsu_axi_master.sv
// LSU to AXI4 initiator: one outstanding single-beat read or write at a time.
// Optional watchdog abort enabled by defining LSU_AXI_TIMEOUT_EN.
module lsu_axi_master
  import lsu_axi_master_pkg::*;
#(
  parameter int          ADDR_W         = 32,
  parameter int          DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2:0]          req_size,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  lsu_axi_master_if.master    axi
);

  lsu_state_e          state_reg,   state_next;
  logic [ADDR_W-1:0]   addr_reg,    addr_next;
  logic [2:0]          size_reg,    size_next;
  logic [DATA_W-1:0]   wdata_reg,   wdata_next;
  logic [DATA_W/8-1:0] wstrb_reg,   wstrb_next;
  logic                we_reg,      we_next;
  logic [DATA_W-1:0]   rdata_reg,   rdata_next;
  logic                err_reg,     err_next;
  logic                req_ready_reg, req_ready_next;
  logic                arvalid_reg, arvalid_next;
  logic                rready_reg,  rready_next;
  logic                awvalid_reg, awvalid_next;
  logic                wvalid_reg,  wvalid_next;
  logic                bready_reg,  bready_next;
  logic                aw_done_reg, aw_done_next;
  logic                w_done_reg,  w_done_next;

  logic req_hs, ar_hs, r_hs, aw_hs, w_hs, b_hs;

  assign req_hs = req_valid && req_ready_reg;
  assign ar_hs  = arvalid_reg && axi.arready;
  assign r_hs   = rready_reg && axi.rvalid;
  assign aw_hs  = awvalid_reg && axi.awready;
  assign w_hs   = wvalid_reg && axi.wready;
  assign b_hs   = bready_reg && axi.bvalid;

`ifdef LSU_AXI_TIMEOUT_EN
  logic wd_expired;
  logic wd_run;

  assign wd_run = is_busy(state_reg);

  lsu_axi_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (req_hs),
    .run     (wd_run),
    .expired (wd_expired)
  );
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      size_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      we_reg        <= 1'b0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
      req_ready_reg <= 1'b1;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      size_reg      <= size_next;
      wdata_reg     <= wdata_next;
      wstrb_reg     <= wstrb_next;
      we_reg        <= we_next;
      rdata_reg     <= rdata_next;
      err_reg       <= err_next;
      req_ready_reg <= req_ready_next;
      arvalid_reg   <= arvalid_next;
      rready_reg    <= rready_next;
      awvalid_reg   <= awvalid_next;
      wvalid_reg    <= wvalid_next;
      bready_reg    <= bready_next;
      aw_done_reg   <= aw_done_next;
      w_done_reg    <= w_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    size_next      = size_reg;
    wdata_next     = wdata_reg;
    wstrb_next     = wstrb_reg;
    we_next        = we_reg;
    rdata_next     = rdata_reg;
    err_next       = err_reg;
    req_ready_next = req_ready_reg;
    arvalid_next   = arvalid_reg;
    rready_next    = rready_reg;
    awvalid_next   = awvalid_reg;
    wvalid_next    = wvalid_reg;
    bready_next    = bready_reg;
    aw_done_next   = aw_done_reg;
    w_done_next    = w_done_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (req_hs) begin
          addr_next      = req_addr;
          size_next      = req_size;
          wdata_next     = req_wdata;
          wstrb_next     = req_wstrb;
          we_next        = req_we;
          rdata_next     = '0;
          err_next       = 1'b0;
          req_ready_next = 1'b0;
          aw_done_next   = 1'b0;
          w_done_next    = 1'b0;
          if (req_we) begin
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            state_next   = ST_AW_W;
          end else begin
            arvalid_next = 1'b1;
            state_next   = ST_AR;
          end
        end
      end
      ST_AR: begin
        if (ar_hs) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          state_next   = ST_R;
        end
      end
      ST_R: begin
        if (r_hs) begin
          rdata_next  = axi.rdata;
          err_next    = (axi.rresp != RESP_OKAY) || !axi.rlast || (axi.rid != DEFAULT_ID);
          rready_next = 1'b0;
          state_next  = ST_RESP;
        end
      end
      ST_AW_W: begin
        if (aw_hs) begin
          awvalid_next = 1'b0;
          aw_done_next = 1'b1;
        end
        if (w_hs) begin
          wvalid_next = 1'b0;
          w_done_next = 1'b1;
        end
        // Either channel may finish first; this cycle's handshake counts as done.
        if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
          bready_next = 1'b1;
          state_next  = ST_B;
        end
      end
      ST_B: begin
        if (b_hs) begin
          bready_next = 1'b0;
          err_next    = (axi.bresp != RESP_OKAY);
          state_next  = ST_RESP;
        end
      end
      ST_RESP: begin
        req_ready_next = 1'b1;
        state_next     = ST_IDLE;
      end
      default: begin
        req_ready_next = 1'b1;
        state_next     = ST_IDLE;
      end
    endcase

`ifdef LSU_AXI_TIMEOUT_EN
    // Abort wins over any handshake landing in the same cycle.
    if (wd_run && wd_expired) begin
      arvalid_next = 1'b0;
      rready_next  = 1'b0;
      awvalid_next = 1'b0;
      wvalid_next  = 1'b0;
      bready_next  = 1'b0;
      rdata_next   = '0;
      err_next     = 1'b1;
      state_next   = ST_RESP;
    end
`endif
  end

  assign req_ready  = req_ready_reg;
  assign resp_valid = (state_reg == ST_RESP);
  assign resp_rdata = (resp_valid && !we_reg) ? rdata_reg : '0;
  assign resp_err   = resp_valid && err_reg;

  assign axi.araddr  = addr_reg;
  assign axi.arvalid = arvalid_reg;
  assign axi.arid    = DEFAULT_ID;
  assign axi.arlen   = SINGLE_BEAT_LEN;
  assign axi.arsize  = size_reg;
  assign axi.arburst = BURST_INCR;
  assign axi.rready  = rready_reg;
  assign axi.awaddr  = addr_reg;
  assign axi.awvalid = awvalid_reg;
  assign axi.wdata   = wdata_reg;
  assign axi.wstrb   = wstrb_reg;
  assign axi.wvalid  = wvalid_reg;
  assign axi.bready  = bready_reg;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Self-checking bench for lsu_axi_master: randomized AXI responder plus a transaction-level model.
// Build with LSU_AXI_TIMEOUT_EN defined to exercise the watchdog abort path.
module tb_lsu_axi_master;
  import lsu_axi_master_pkg::*;

  localparam int TO_CYC = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_size = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  always #5 clk = ~clk;

  lsu_axi_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  lsu_axi_master #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .axi(bus)
  );

  int checks = 0;
  int failures = 0;

  // Responder controls: a fixed delay >= 0, or -1 for a random delay up to max_dly.
  int fix_ar = 0, fix_r = 0, fix_aw = 0, fix_w = 0, fix_b = 0;
  int max_dly = 0;
  bit r_block = 1'b0;
  bit flush = 1'b0;
  bit use_fixed = 1'b1;
  logic [31:0] fx_rdata = '0;
  logic [1:0]  fx_rresp = 2'b00;
  logic [1:0]  fx_bresp = 2'b00;
  int b_hs_cnt = 0;

  // Current request as seen by the model, and the response the model expects.
  logic [31:0] cur_addr, cur_wdata;
  logic [2:0]  cur_size;
  logic [3:0]  cur_wstrb;
  logic [31:0] exp_rdata_m;
  logic        exp_err_m;
  bit          exp_have;

  function automatic int pick(int fixed);
    return (fixed >= 0) ? fixed : int'($urandom_range(0, max_dly));
  endfunction

  // Outputs are observed and inputs driven on negedges; a handshake is
  // decided here and takes effect at the following posedge.
  initial begin : responder
    int ar_d, r_d, aw_d, w_d, b_d;
    bit ar_arm, aw_arm, w_arm, r_pend, b_pend, aw_got, w_got;
    bit p_arv, p_awv, p_wv, p_ar_hs, p_aw_hs, p_w_hs;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [3:0]  p_wstrb;
    logic [31:0] r_dat;
    logic [1:0]  r_rsp, b_rsp;
    logic [3:0]  r_id;
    logic        r_last;
    ar_d = 0; r_d = 0; aw_d = 0; w_d = 0; b_d = 0;
    ar_arm = 0; aw_arm = 0; w_arm = 0; r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
    p_arv = 0; p_awv = 0; p_wv = 0; p_ar_hs = 0; p_aw_hs = 0; p_w_hs = 0;
    p_araddr = '0; p_awaddr = '0; p_wdata = '0; p_wstrb = '0;
    r_dat = '0; r_rsp = '0; b_rsp = '0; r_id = '0; r_last = 1'b1;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 0; bus.rid = '0;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = '0;
    forever begin
      @(negedge clk);
      if (!rst || flush) begin
        ar_arm = 0; aw_arm = 0; w_arm = 0; r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        p_arv = 0; p_awv = 0; p_wv = 0;
        bus.arready = 0; bus.rvalid = 0; bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
        continue;
      end
      if (p_arv && !p_ar_hs) begin
        checks++;
        if (bus.arvalid !== 1'b1 || bus.araddr !== p_araddr) begin
          failures++;
          $display("FAIL ar_stable: arvalid=%b araddr=%h, required 1 / %h", bus.arvalid, bus.araddr, p_araddr);
        end
      end
      if (p_awv && !p_aw_hs) begin
        checks++;
        if (bus.awvalid !== 1'b1 || bus.awaddr !== p_awaddr) begin
          failures++;
          $display("FAIL aw_stable: awvalid=%b awaddr=%h, required 1 / %h", bus.awvalid, bus.awaddr, p_awaddr);
        end
      end
      if (p_wv && !p_w_hs) begin
        checks++;
        if (bus.wvalid !== 1'b1 || bus.wdata !== p_wdata || bus.wstrb !== p_wstrb) begin
          failures++;
          $display("FAIL w_stable: wvalid=%b wdata=%h wstrb=%b, required 1 / %h / %b",
                   bus.wvalid, bus.wdata, bus.wstrb, p_wdata, p_wstrb);
        end
      end
      // R before AR so read data never appears in the same cycle as its address handshake.
      bus.rvalid = 0;
      if (r_pend && !r_block) begin
        if (r_d > 0) r_d--;
        else begin
          bus.rvalid = 1; bus.rdata = r_dat; bus.rresp = r_rsp; bus.rid = r_id; bus.rlast = r_last;
          if (bus.rready === 1'b1) begin
            exp_rdata_m = r_dat;
            exp_err_m   = (r_rsp != 2'b00) || !r_last || (r_id != 4'd0);
            exp_have    = 1;
            r_pend      = 0;
          end
        end
      end
      bus.bvalid = 0;
      if (b_pend) begin
        if (b_d > 0) b_d--;
        else begin
          bus.bvalid = 1; bus.bresp = b_rsp;
          if (bus.bready === 1'b1) begin
            exp_rdata_m = '0;
            exp_err_m   = (b_rsp != 2'b00);
            exp_have    = 1;
            b_pend      = 0;
            b_hs_cnt++;
          end
        end
      end
      bus.arready = 0;
      if (bus.arvalid === 1'b1) begin
        if (!ar_arm) begin ar_d = pick(fix_ar); ar_arm = 1; end
        if (ar_d > 0) ar_d--;
        else begin
          bus.arready = 1; ar_arm = 0;
          checks++;
          if (bus.araddr !== cur_addr || bus.arsize !== cur_size || bus.arlen !== 8'd0 ||
              bus.arburst !== 2'b01 || bus.arid !== 4'd0) begin
            failures++;
            $display("FAIL ar_fields: addr=%h size=%0d len=%0d burst=%b id=%0d, required %h/%0d/0/01/0",
                     bus.araddr, bus.arsize, bus.arlen, bus.arburst, bus.arid, cur_addr, cur_size);
          end
          r_pend = 1; r_d = pick(fix_r);
          if (use_fixed) begin
            r_dat = fx_rdata; r_rsp = fx_rresp; r_id = '0; r_last = 1'b1;
          end else begin
            r_dat  = $urandom;
            r_rsp  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            r_id   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            r_last = ($urandom_range(0, 9) != 0);
          end
        end
      end
      bus.awready = 0;
      if (bus.awvalid === 1'b1) begin
        if (!aw_arm) begin aw_d = pick(fix_aw); aw_arm = 1; end
        if (aw_d > 0) aw_d--;
        else begin
          bus.awready = 1; aw_arm = 0; aw_got = 1;
          checks++;
          if (bus.awaddr !== cur_addr) begin
            failures++;
            $display("FAIL aw_fields: awaddr=%h, required %h", bus.awaddr, cur_addr);
          end
        end
      end
      bus.wready = 0;
      if (bus.wvalid === 1'b1) begin
        if (!w_arm) begin w_d = pick(fix_w); w_arm = 1; end
        if (w_d > 0) w_d--;
        else begin
          bus.wready = 1; w_arm = 0; w_got = 1;
          checks++;
          if (bus.wdata !== cur_wdata || bus.wstrb !== cur_wstrb) begin
            failures++;
            $display("FAIL w_fields: wdata=%h wstrb=%b, required %h / %b", bus.wdata, bus.wstrb, cur_wdata, cur_wstrb);
          end
        end
      end
      if (aw_got && w_got) begin
        b_pend = 1; b_d = pick(fix_b); aw_got = 0; w_got = 0;
        b_rsp = use_fixed ? fx_bresp : (($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      end
      p_arv = bus.arvalid; p_ar_hs = bus.arvalid && bus.arready; p_araddr = bus.araddr;
      p_awv = bus.awvalid; p_aw_hs = bus.awvalid && bus.awready; p_awaddr = bus.awaddr;
      p_wv  = bus.wvalid;  p_w_hs  = bus.wvalid && bus.wready;   p_wdata = bus.wdata; p_wstrb = bus.wstrb;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting posedge (cycle 2).
  task automatic issue_req(input logic we, input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
    int n;
    cur_addr = addr; cur_size = size; cur_wdata = wdata; cur_wstrb = wstrb; exp_have = 0;
    req_valid = 1; req_we = we; req_addr = addr; req_size = size; req_wdata = wdata; req_wstrb = wstrb;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL req_accept_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
    end
    @(negedge clk);
    req_valid = 0;
  endtask

  // Counts cycles with the accept cycle as cycle 1; returns at the resp_valid negedge.
  task automatic wait_resp(output int cyc);
    cyc = 2;
    while (resp_valid !== 1'b1 && cyc < 400) begin @(negedge clk); cyc++; end
    checks++;
    if (resp_valid !== 1'b1) begin
      failures++;
      $display("FAIL resp_timeout: resp_valid=%b after %0d cycles, required 1", resp_valid, cyc);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({req_ready, bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready, resp_valid, resp_err} !== 8'b1000_0000) begin
      failures++;
      $display("FAIL %s_ctrl: rdy/arv/awv/wv/rr/br/rv/err=%b, required 10000000", tag,
               {req_ready, bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready, resp_valid, resp_err});
    end
    checks++;
    if (resp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL %s_rdata: resp_rdata=%h, required 0", tag, resp_rdata);
    end
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1;
    @(negedge clk);
    check_idle_outputs("post_reset");
  endtask

  task automatic test_load_basic();
    int cyc;
    fix_ar = 0; fix_r = 0; use_fixed = 1; fx_rdata = 32'h1234_5678; fx_rresp = 2'b00;
    issue_req(1'b0, 32'hA000_0048, SIZE_W, 32'hFFFF_FFFF, 4'hF);
    wait_resp(cyc);
    checks++;
    if (cyc != 4) begin
      failures++;
      $display("FAIL load_latency: resp_valid in cycle %0d, required 4", cyc);
    end
    checks++;
    if (resp_rdata !== 32'h1234_5678 || resp_err !== 1'b0) begin
      failures++;
      $display("FAIL load_basic: rdata=%h err=%b, required 12345678 / 0", resp_rdata, resp_err);
    end
    $display("load_basic addr=a0000048 rdata=%h err=%b cycle=%0d", resp_rdata, resp_err, cyc);
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL resp_pulse: resp_valid=%b req_ready=%b, required 0 / 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_store_order();
    int cyc, w_first, aw_first, b0;
    fix_aw = 3; fix_w = 0; fix_b = 0; use_fixed = 1; fx_bresp = 2'b00;
    b0 = b_hs_cnt;
    issue_req(1'b1, 32'h8000_0010, SIZE_W, 32'hDEAD_BEEF, 4'b0011);
    cyc = 2; w_first = -1; aw_first = -1;
    while (resp_valid !== 1'b1 && cyc < 100) begin
      if (bus.wvalid === 1'b0 && w_first < 0) w_first = cyc;
      if (bus.awvalid === 1'b0 && aw_first < 0) aw_first = cyc;
      @(negedge clk); cyc++;
    end
    checks++;
    if (w_first != 3 || aw_first != 6) begin
      failures++;
      $display("FAIL store_order: wvalid dropped cycle %0d awvalid dropped cycle %0d, required 3 / 6", w_first, aw_first);
    end
    checks++;
    if (b_hs_cnt - b0 != 1) begin
      failures++;
      $display("FAIL store_bhs: %0d B handshakes, required 1", b_hs_cnt - b0);
    end
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0 || cyc != 7) begin
      failures++;
      $display("FAIL store_resp: valid=%b err=%b rdata=%h cycle=%0d, required 1 / 0 / 0 / 7", resp_valid, resp_err, resp_rdata, cyc);
    end
    $display("store_order addr=80000010 err=%b cycle=%0d", resp_err, cyc);
    fix_aw = 0;
    @(negedge clk);
  endtask

  task automatic test_load_err_b2b();
    int cyc;
    use_fixed = 1; fx_rdata = 32'h0BAD_0000; fx_rresp = 2'b10;
    issue_req(1'b0, 32'h2000_0004, SIZE_W, '0, '0);
    wait_resp(cyc);
    checks++;
    if (resp_err !== 1'b1 || resp_rdata !== 32'h0BAD_0000) begin
      failures++;
      $display("FAIL load_slverr: err=%b rdata=%h, required 1 / 0bad0000", resp_err, resp_rdata);
    end
    $display("load_err addr=20000004 rdata=%h err=%b", resp_rdata, resp_err);
    fx_rresp = 2'b00; fx_rdata = 32'h5555_AAAA;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready: req_ready=%b the cycle after resp, required 1", req_ready);
    end
    issue_req(1'b0, 32'h2000_0008, SIZE_H, '0, '0);
    checks++;
    if (bus.arvalid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_issue: arvalid=%b after back-to-back request, required 1", bus.arvalid);
    end
    wait_resp(cyc);
    checks++;
    if (resp_err !== 1'b0 || resp_rdata !== 32'h5555_AAAA || cyc != 4) begin
      failures++;
      $display("FAIL b2b_resp: err=%b rdata=%h cycle=%0d, required 0 / 5555aaaa / 4", resp_err, resp_rdata, cyc);
    end
    $display("load_b2b addr=20000008 rdata=%h err=%b", resp_rdata, resp_err);
    @(negedge clk);
  endtask

  task automatic test_random();
    int cyc;
    logic        we;
    logic [2:0]  sz;
    logic [31:0] a, mask;
    fix_ar = -1; fix_r = -1; fix_aw = -1; fix_w = -1; fix_b = -1; max_dly = 7; use_fixed = 0;
    for (int t = 0; t < 200; t++) begin
      we   = 1'($urandom_range(0, 1));
      sz   = 3'($urandom_range(0, 2));
      mask = (32'd1 << sz) - 32'd1;
      a    = $urandom & ~mask;
      issue_req(we, a, sz, $urandom, 4'($urandom));
      wait_resp(cyc);
      checks++;
      if (!exp_have || resp_rdata !== exp_rdata_m || resp_err !== exp_err_m) begin
        failures++;
        $display("FAIL rand_resp[%0d]: rdata=%h err=%b, required %h / %b (model ready=%0d)",
                 t, resp_rdata, resp_err, exp_rdata_m, exp_err_m, exp_have);
      end
      $display("rand txn %0d we=%0d addr=%h size=%0d rdata=%h err=%b cycle=%0d", t, we, a, sz, resp_rdata, resp_err, cyc);
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        failures++;
        $display("FAIL rand_pulse[%0d]: resp_valid=%b req_ready=%b, required 0 / 1", t, resp_valid, req_ready);
      end
    end
    fix_ar = 0; fix_r = 0; fix_aw = 0; fix_w = 0; fix_b = 0; max_dly = 0; use_fixed = 1;
  endtask

  task automatic test_reset_mid_read();
    int n, seen;
    r_block = 1;
    issue_req(1'b0, 32'h1000_0000, SIZE_W, '0, '0);
    n = 0;
    while (bus.rready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (bus.rready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_reach_r: rready=%b, required 1", bus.rready);
    end
    rst = 0;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    @(negedge clk);
    rst = 1;
    r_block = 0;
    seen = 0;
    repeat (6) begin @(negedge clk); if (resp_valid === 1'b1) seen++; end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL mid_reset_resp: %0d resp_valid cycles after abandoned read, required 0", seen);
    end
    $display("reset_mid_read abandoned, resp pulses=%0d", seen);
  endtask

  task automatic test_stall();
    int cyc, seen;
    use_fixed = 1; fx_rdata = 32'hCAFE_F00D; fx_rresp = 2'b00;
    r_block = 1;
    issue_req(1'b0, 32'h3000_0010, SIZE_W, '0, '0);
`ifdef LSU_AXI_TIMEOUT_EN
    wait_resp(cyc);
    checks++;
    if (resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL timeout_resp: err=%b rdata=%h, required 1 / 0", resp_err, resp_rdata);
    end
    $display("timeout addr=30000010 err=%b rdata=%h cycle=%0d", resp_err, resp_rdata, cyc);
    // Release the late beat; with rready low it must be dropped.
    r_block = 0;
    seen = 0;
    repeat (6) begin @(negedge clk); if (resp_valid === 1'b1 || bus.rready === 1'b1) seen++; end
    checks++;
    if (seen != 0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL timeout_late_beat: %0d reactions, req_ready=%b, required 0 / 1", seen, req_ready);
    end
    flush = 1;
    @(negedge clk);
    @(negedge clk);
    flush = 0;
`else
    seen = 0;
    repeat (40) begin @(negedge clk); if (resp_valid === 1'b1) seen++; end
    checks++;
    if (seen != 0 || bus.rready !== 1'b1) begin
      failures++;
      $display("FAIL stall_wait: %0d resp pulses, rready=%b, required 0 / 1", seen, bus.rready);
    end
    r_block = 0;
    wait_resp(cyc);
    checks++;
    if (!exp_have || resp_rdata !== 32'hCAFE_F00D || resp_err !== 1'b0) begin
      failures++;
      $display("FAIL stall_resp: rdata=%h err=%b, required cafef00d / 0", resp_rdata, resp_err);
    end
    $display("stall addr=30000010 rdata=%h err=%b cycle=%0d", resp_rdata, resp_err, cyc);
`endif
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "time limit reached");
  end

  initial begin
    test_reset();
    test_load_basic();
    test_store_order();
    test_load_err_b2b();
    test_random();
    test_reset_mid_read();
    test_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
- AXI4 initiator for the CPU load/store unit.
- Converts a single-request LSU interface into single-beat AXI4 read (AR/R) or write (AW/W/B) transactions.
- Drives the crossbar toward CLINT, SRAM and UART responders.
- One outstanding transaction at a time.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; the strobe width is DATA_W/8.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only when the optional feature is enabled.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- req_valid  in  1  LSU request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  3  AXI size encoding: 0 = byte, 1 = half, 2 = word
- req_wdata  in  32  store data, already lane-aligned
- req_wstrb  in  4  store byte strobes
- resp_valid  out  1  single-cycle completion pulse
- resp_rdata  out  32  load data; 0 for stores
- resp_err  out  1  bus error flag
- araddr  out  32  AXI read address
- arvalid  out  1  AXI read address valid
- arready  in  1  AXI read address ready
- arid  out  4  AXI read ID
- arlen  out  8  AXI burst length
- arsize  out  3  AXI transfer size
- arburst  out  2  AXI burst type
- rdata  in  32  AXI read data
- rresp  in  2  AXI read response
- rvalid  in  1  AXI read data valid
- rready  out  1  AXI read data ready
- rlast  in  1  AXI last beat
- rid  in  4  AXI read ID
- awaddr  out  32  AXI write address
- awvalid  out  1  AXI write address valid
- awready  in  1  AXI write address ready
- wdata  out  32  AXI write data
- wstrb  out  4  AXI write strobes
- wvalid  out  1  AXI write data valid
- wready  in  1  AXI write data ready
- bresp  in  2  AXI write response
- bvalid  in  1  AXI write response valid
- bready  out  1  AXI write response ready

Behaviour:
- Reset (rst = 0 at posedge clk): state IDLE, req_ready = 1, and the following outputs are 0: arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_err, resp_rdata.
- Reset mid-transaction abandons the transaction immediately; no response is produced.
- States: IDLE, AR, R, AW_W, B, RESP.
- IDLE:
  - req_ready = 1.
  - On handshake, latch addr, size, wdata, wstrb and we; req_ready <= 0.
  - Load: arvalid <= 1, go to AR.
  - Store: awvalid <= 1, wvalid <= 1, go to AW_W.
- AR:
  - arvalid is held with stable fields until arready.
  - Fixed fields: arid = 0, arlen = 0, arsize = latched size, arburst = 2'b01.
  - On handshake: arvalid <= 0, rready <= 1, go to R.
- R:
  - On rvalid && rready, capture rdata; rready <= 0; go to RESP.
  - err = (rresp != 0) || !rlast || (rid != 0).
- AW_W:
  - AW and W complete independently; each valid drops on its own handshake.
  - Either may complete first or both in the same cycle.
  - When both have completed (sticky done flags): bready <= 1, go to B.
- B:
  - On bvalid && bready: bready <= 0, err = (bresp != 0), go to RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle with rdata/err.
  - Then return to IDLE with req_ready <= 1.
  - Earliest back-to-back issue: the cycle after RESP.
- valid never depends on ready. Addr/data/strb are stable while valid is high.
- Minimum latency (responder ready at once): load = 4 cycles from request accept to resp_valid; store = 4 cycles.
- Loads ignore req_wdata/req_wstrb.

Optional Feature:
- Macro: LSU_AXI_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on request accept and increments in AR/R/AW_W/B.
  - Reaching TIMEOUT_CYCLES deasserts all valids/readies, goes to RESP with resp_err = 1 and resp_rdata = 0.
  - Late responder beats after a timeout are dropped while rready/bready = 0.
- Undefined: no counter; the block waits indefinitely.

Decomposition:
- Shared package holds:
  - state encoding localparams;
  - AXI constants: BURST_INCR = 2'b01, RESP_OKAY = 2'b00, SIZE_B/H/W;
  - default ID = 0.
- Sub-module lsu_axi_watchdog (counter plus compare) is instantiated only under LSU_AXI_TIMEOUT_EN.

Test Plan:
- Load 0xA000_0048, arready/rvalid same-cycle ready, rdata = 0x1234_5678, rresp = 0 -> arsize = 2, arlen = 0, resp_rdata = 0x1234_5678, resp_err = 0, resp_valid 4 cycles after accept.
- Store 0x8000_0010, wdata = 0xDEAD_BEEF, wstrb = 4'b0011; wready 3 cycles before awready -> wvalid drops first, awvalid is held, a single bready handshake follows, resp_err = 0.
- Load with rresp = 2'b10 -> resp_err = 1; a following request is accepted the cycle after RESP.
- Random ready/valid delays (0-7 cycles) on all channels, 200 mixed transactions -> valid stays stable until handshake; data matches the scoreboard.
- Reset asserted while in R -> all valids/readies are 0 next cycle, req_ready = 1, no resp_valid.
- LSU_AXI_TIMEOUT_EN with TIMEOUT_CYCLES = 16 and a responder that never asserts rvalid -> resp_err = 1, resp_rdata = 0, and a late rvalid is ignored.
